evo_truth_table_tester: RTL and testbench
=========================================

Name: evo_truth_table_tester

Overview:
Sequential test harness for evolved combinational circuits built from LCELL-buffered gate netlists.
- Drives every input vector of an N-input evolved circuit in turn.
- Waits a programmable settle time, then samples the circuit output repeatedly to detect oscillation from feedback loops.
- Scores each vector against a target truth table and reports per-vector pass mask, mismatch count, unstable count and fitness score.
- Sits between the evolution controller, which supplies the target and start, and the evolved circuit instance.

Parameters:
NUM_INPUTS, 4, evolved circuit input width; vectors 0..2**NUM_INPUTS-1
SETTLE_CYCLES, 4, cycles waited after applying a vector before sampling; minimum 3, covers the 2-flop synchroniser
NUM_SAMPLES, 8, consecutive output samples taken per vector; minimum 1

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a test run; sampled only in IDLE
expected  in  2**NUM_INPUTS  target truth table; bit v = required output for vector v; latched on accepted start
dut_in  out  NUM_INPUTS  registered vector driven to the evolved circuit
dut_out  in  1  evolved circuit output; asynchronous, 2-flop synchronised internally
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse at end of run
pass_mask  out  2**NUM_INPUTS  bit v = 1 if vector v was stable and correct
mismatch_count  out  NUM_INPUTS+1  vectors stable but wrong
unstable_count  out  NUM_INPUTS+1  vectors whose samples disagreed
score  out  NUM_INPUTS+1  passing vectors = popcount(pass_mask)

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; dut_in, busy, done, pass_mask, mismatch_count, unstable_count and score all 0; synchroniser flops cleared. Reset overrides every other event, including mid-run; no done is produced for an aborted run.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, EVAL, DONE.
- IDLE:
  - start=1 latches expected, clears vec, all result outputs and counters, and goes to APPLY.
  - start=0 holds previous results.
- APPLY (1 cycle): dut_in <= vec; load settle counter; go to SETTLE.
- SETTLE: wait exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: exactly NUM_SAMPLES cycles. Each cycle, add the synchronised output into ones_cnt, width clog2(NUM_SAMPLES+1). Then go to EVAL.
- EVAL (1 cycle):
  - ones_cnt==0 gives stable value 0; ones_cnt==NUM_SAMPLES gives stable value 1. Any other count: unstable_count+1, pass_mask[vec]=0.
  - Stable and value==expected[vec]: pass_mask[vec]=1, score+1.
  - Stable and value!=expected[vec]: mismatch_count+1.
  - Clear ones_cnt. If vec==2**NUM_INPUTS-1 go to DONE; else vec+1 and go to APPLY.
- DONE (1 cycle): done=1, busy=0 on the following cycle; go to IDLE. Results hold until the next accepted start or reset.
- Cycles per vector: SETTLE_CYCLES+NUM_SAMPLES+2.
- done is high in the cycle (2**NUM_INPUTS)*(SETTLE_CYCLES+NUM_SAMPLES+2) after the start-accepting edge.
- Boundary conditions:
  - start while busy is ignored.
  - start held high continuously re-triggers only from IDLE, so runs are back-to-back with one IDLE cycle between them.
  - Invariant: mismatch_count+unstable_count+score == 2**NUM_INPUTS at done.
  - Counters cannot wrap; width NUM_INPUTS+1 holds 2**NUM_INPUTS.
  - dut_in holds the last vector after the run until the next APPLY or reset.
- expected changes after start are ignored for that run.

Test Plan:
- Reset → with rst_n=0 held 2 cycles, all outputs read 0 and state is IDLE; start asserted during reset has no effect.
- DUT model out=in[1]&in[0] (zero delay), expected=16'h8888, defaults → done 224 cycles after start; pass_mask=16'hFFFF, score=16, mismatch_count=0, unstable_count=0.
- Same DUT, expected=16'h8889 → pass_mask=16'hFFFE, score=15, mismatch_count=1, unstable_count=0.
- DUT toggles output every cycle while dut_in==5, else correct for 16'h8888 → unstable_count=1, pass_mask=16'hFFDF, score=15; invariant holds.
- start pulsed again at vector 3 → ignored, done still at cycle 224; then rst_n=0 for 1 cycle at vector 7 of a second run → next cycle busy=0, dut_in=0, no done; a fresh start then completes normally.
- NUM_INPUTS=2, SETTLE_CYCLES=3, NUM_SAMPLES=1, XOR DUT, expected=4'b0110 → done after 24 cycles, score=3'd4, pass_mask=4'hF.

Source files
------------

// File: rtl/evo_truth_table_tester.sv
// Purpose: sequential truth-table harness for an evolved combinational circuit; drives every
//          input vector, waits for settling, samples the output to detect oscillation, scores vs target.
// Latency: done pulses (2**NUM_INPUTS)*(SETTLE_CYCLES+NUM_SAMPLES+2) cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE, start while busy is ignored.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_start              begin a run (IDLE only)
//   i_expected           target truth table, bit v = required output for vector v (latched at start)
//   o_dut_in             registered vector driven to the evolved circuit
//   i_dut_out            evolved circuit output (asynchronous, synchronised here)
//   o_busy, o_done       run in progress / one-cycle end-of-run pulse
//   o_pass_mask          bit v = vector v was stable and correct
//   o_mismatch_count     vectors stable but wrong
//   o_unstable_count     vectors whose samples disagreed
//   o_score              passing vectors
module evo_truth_table_tester #(
    parameter int NUM_INPUTS    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SAMPLES   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [2**NUM_INPUTS-1:0]   i_expected,
    output logic [NUM_INPUTS-1:0]      o_dut_in,
    input  logic                       i_dut_out,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [2**NUM_INPUTS-1:0]   o_pass_mask,
    output logic [NUM_INPUTS:0]        o_mismatch_count,
    output logic [NUM_INPUTS:0]        o_unstable_count,
    output logic [NUM_INPUTS:0]        o_score
);

    localparam int NV   = 2**NUM_INPUTS;
    localparam int CMAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int OW   = $clog2(NUM_SAMPLES + 1);

    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         SETTLE_LD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]         SAMPLE_LD  = CW'(NUM_SAMPLES - 1);
    localparam logic [NUM_INPUTS:0]   RES_ONE    = (NUM_INPUTS + 1)'(1);
    localparam logic [NUM_INPUTS-1:0] VEC_ONE    = NUM_INPUTS'(1);
    localparam logic [NUM_INPUTS-1:0] VEC_LAST   = {NUM_INPUTS{1'b1}};
    localparam logic [OW-1:0]         ONES_FULL  = OW'(NUM_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [NV-1:0]          r_expected;
    logic [NUM_INPUTS-1:0]  r_vec;
    logic [NUM_INPUTS-1:0]  r_dut_in;
    logic [CW-1:0]          r_cnt;
    logic [OW-1:0]          r_ones;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_busy;
    logic                   r_done;
    logic [NV-1:0]          r_pass_mask;
    logic [NUM_INPUTS:0]    r_mismatch;
    logic [NUM_INPUTS:0]    r_unstable;
    logic [NUM_INPUTS:0]    r_score;

    logic                   w_last_vec;
    logic                   w_cnt_zero;
    logic                   w_all_zero;
    logic                   w_all_one;
    logic                   w_stable;

    assign w_last_vec = (r_vec == VEC_LAST);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_all_zero = (r_ones == '0);
    assign w_all_one  = (r_ones == ONES_FULL);
    assign w_stable   = w_all_zero | w_all_one;

    // Two-flop synchroniser: the evolved circuit may contain combinational loops
    // and is treated as fully asynchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_dut_out;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_APPLY;
            S_APPLY:  w_next = S_SETTLE;
            S_SETTLE: if (w_cnt_zero) w_next = S_SAMPLE;
            S_SAMPLE: if (w_cnt_zero) w_next = S_EVAL;
            S_EVAL:   w_next = w_last_vec ? S_DONE : S_APPLY;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_expected  <= '0;
            r_vec       <= '0;
            r_dut_in    <= '0;
            r_cnt       <= '0;
            r_ones      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_mask <= '0;
            r_mismatch  <= '0;
            r_unstable  <= '0;
            r_score     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Results from the previous run stay visible until a new start.
                    if (i_start) begin
                        r_expected  <= i_expected;
                        r_vec       <= '0;
                        r_ones      <= '0;
                        r_cnt       <= '0;
                        r_pass_mask <= '0;
                        r_mismatch  <= '0;
                        r_unstable  <= '0;
                        r_score     <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_dut_in <= r_vec;
                    r_cnt    <= SETTLE_LD;
                end
                S_SETTLE: begin
                    // Settle and sample phases share one down-counter.
                    if (w_cnt_zero) r_cnt <= SAMPLE_LD;
                    else            r_cnt <= r_cnt - CNT_ONE;
                end
                S_SAMPLE: begin
                    r_ones <= r_ones + OW'(r_sync2);
                    if (!w_cnt_zero) r_cnt <= r_cnt - CNT_ONE;
                end
                S_EVAL: begin
                    if (!w_stable) begin
                        r_unstable         <= r_unstable + RES_ONE;
                        r_pass_mask[r_vec] <= 1'b0;
                    end else if (w_all_one == r_expected[r_vec]) begin
                        r_pass_mask[r_vec] <= 1'b1;
                        r_score            <= r_score + RES_ONE;
                    end else begin
                        r_mismatch <= r_mismatch + RES_ONE;
                    end
                    r_ones <= '0;
                    if (w_last_vec) r_done <= 1'b1;
                    else            r_vec  <= r_vec + VEC_ONE;
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_dut_in         = r_dut_in;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass_mask      = r_pass_mask;
    assign o_mismatch_count = r_mismatch;
    assign o_unstable_count = r_unstable;
    assign o_score          = r_score;

endmodule

// File: tb/tb_evo_truth_table_tester.sv
module tb_evo_truth_table_tester;

    localparam int RUN_CYC = 16 * (4 + 8 + 2);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy, done;
    logic [15:0] pass_mask;
    logic [4:0]  mm, un, sc;

    logic        start2;
    logic [3:0]  exp2;
    logic [1:0]  dut_in2;
    logic        dut_out2;
    logic        busy2, done2;
    logic [3:0]  pm2;
    logic [2:0]  mm2, un2, sc2;

    // Behavioural evolved circuit: lookup table, with selected vectors oscillating.
    logic [15:0] ckt_tt;
    logic [15:0] ckt_osc;
    logic        tog = 1'b0;
    always @(negedge clk) tog <= ~tog;
    assign dut_out  = ckt_osc[dut_in] ? tog : ckt_tt[dut_in];
    assign dut_out2 = dut_in2[1] ^ dut_in2[0];

    evo_truth_table_tester u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_expected(expected),
        .o_dut_in(dut_in), .i_dut_out(dut_out), .o_busy(busy), .o_done(done),
        .o_pass_mask(pass_mask), .o_mismatch_count(mm), .o_unstable_count(un),
        .o_score(sc)
    );

    evo_truth_table_tester #(.NUM_INPUTS(2), .SETTLE_CYCLES(3), .NUM_SAMPLES(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_expected(exp2),
        .o_dut_in(dut_in2), .i_dut_out(dut_out2), .o_busy(busy2), .o_done(done2),
        .o_pass_mask(pm2), .o_mismatch_count(mm2), .o_unstable_count(un2),
        .o_score(sc2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pm;
        int          mm;
        int          un;
        int          sc;
        int          acc;
    } res_t;

    res_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a vector passes if it never oscillates and its fixed value matches the target.
    function automatic res_t model(input logic [15:0] tt, input logic [15:0] osc,
                                   input logic [15:0] tgt, input int acc);
        res_t r;
        r.pm = '0; r.mm = 0; r.un = 0; r.sc = 0; r.acc = acc;
        for (int v = 0; v < 16; v++) begin
            if (osc[v])              r.un++;
            else if (tt[v] == tgt[v]) begin r.pm[v] = 1'b1; r.sc++; end
            else                     r.mm++;
        end
        return r;
    endfunction

    function automatic logic [15:0] and_tt();
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = ((v & 3) == 3);
        return t;
    endfunction

    // Monitor: every done pulse is matched against the oldest outstanding run.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.acc, RUN_CYC);
                    chk("pass_mask", pass_mask, e.pm);
                    chk("mismatch_count", mm, e.mm);
                    chk("unstable_count", un, e.un);
                    chk("score", sc, e.sc);
                    chk("busy_at_done", busy, 1'b1);
                    chk("invariant", int'(mm) + int'(un) + int'(sc), 16);
                end
            end
        end
    end

    res_t last;

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 2 * RUN_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", sb.size(), 0);
        @(negedge clk);
        chk("hold_busy", busy, 1'b0);
        chk("hold_dut_in", dut_in, 4'hF);
        chk("hold_pass_mask", pass_mask, last.pm);
        chk("hold_score", sc, last.sc);
    endtask

    // Called at a negedge while the DUT is idle; poke>0 re-pulses start mid-run.
    task automatic run(input logic [15:0] tt, input logic [15:0] osc,
                       input logic [15:0] tgt, input int poke);
        ckt_tt   = tt;
        ckt_osc  = osc;
        expected = tgt;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        last     = model(tt, osc, tgt, cyc);
        sb.push_back(last);
        expected = 16'($urandom);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            expected = ~tgt;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        int acc1;
        logic [15:0] t, o, g;

        rst_n    = 1'b0;
        start    = 1'b1;
        start2   = 1'b0;
        exp2     = 4'b0110;
        expected = 16'h8888;
        ckt_tt   = and_tt();
        ckt_osc  = '0;
        last     = model(ckt_tt, ckt_osc, expected, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dut_in", dut_in, 4'h0);
        chk("rst_pass_mask", pass_mask, 16'h0);
        chk("rst_counts", {mm, un, sc}, 15'h0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);

        run(and_tt(), 16'h0000, 16'h8888, 0);
        run(and_tt(), 16'h0000, 16'h8889, 0);
        run(and_tt(), 16'h0020, 16'h8888, 0);
        // start pulse while the run is at vector 3 must not disturb it
        run(and_tt(), 16'h0000, 16'h8888, 3 * 14 + 2);

        // Reset in the middle of vector 7: run aborts with no done.
        ckt_tt   = and_tt();
        ckt_osc  = '0;
        expected = 16'h8888;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (7 * 14 + 3) @(negedge clk);
        chk("midrun_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_dut_in", dut_in, 4'h0);
        chk("abort_done", done, 1'b0);
        chk("abort_score", sc, 5'd0);
        repeat (RUN_CYC) @(negedge clk);
        run(and_tt(), 16'h0000, 16'h8888, 0);

        // Randomised circuits, targets and oscillating vectors.
        for (int i = 0; i < 6; i++) begin
            t = 16'($urandom);
            g = (i == 0) ? t : 16'($urandom);
            o = (i == 1) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            run(t, o, g, 0);
        end

        // start held high: back-to-back runs with a single IDLE cycle between.
        ckt_tt   = 16'($urandom);
        ckt_osc  = 16'($urandom & $urandom);
        expected = 16'($urandom);
        start    = 1'b1;
        @(negedge clk);
        acc1 = cyc;
        sb.push_back(model(ckt_tt, ckt_osc, expected, acc1));
        last = model(ckt_tt, ckt_osc, expected, acc1 + RUN_CYC + 2);
        sb.push_back(last);
        repeat (RUN_CYC + 2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Small configuration: 2 inputs, XOR circuit.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("n2_latency", n, 24);
        chk("n2_pass_mask", pm2, 4'hF);
        chk("n2_score", sc2, 3'd4);
        chk("n2_fail_counts", {mm2, un2}, 6'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
